// File: rtl/ads_frame_sched.sv
// ads_frame_sched: shares the ADS8686 SPI frame engine between the
// register-init sequence, periodic sample NOP frames and host accesses.
module ads_frame_sched #(
  parameter int unsigned INIT_DLY   = 50,
  parameter int unsigned SMP_PERIOD = 2000
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  input  logic        smp_en,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        frm_start,
  output logic [31:0] frm_cmd,
  input  logic        frm_done,
  input  logic [31:0] frm_rdata,
  output logic        init_done,
  output logic        smp_valid,
  output logic [15:0] smp_data,
  output logic [7:0]  smp_miss
);

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_ISSUE,
    INIT_BUSY,
    IDLE,
    SMP_BUSY,
    HW_BUSY,
    HR_CMD,
    HR_NOP
  } state_t;

  localparam logic [7:0]  OP_WR    = 8'hD0;
  localparam logic [7:0]  OP_RD    = 8'hC8;
  localparam logic [31:0] CMD_NOP  = 32'h0;
  localparam logic [15:0] DLY_LAST = 16'(INIT_DLY - 1);
  localparam logic [15:0] PER_LAST = 16'(SMP_PERIOD - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] dly_q;
  logic [1:0]  k_q;
  logic [1:0]  k_d;
  logic [15:0] cnt_q;
  logic        pend_q;

  logic        start_d;
  logic [31:0] cmd_d;
  logic        ack_d;
  logic [15:0] rdata_d;
  logic        valid_d;
  logic [15:0] sdata_d;
  logic        init_d;
  logic        consume;

  logic        smp_act;
  logic        tick;
  logic        dly_hit;
  logic        rdata_unused;

  assign rdata_unused = ^frm_rdata[15:0];
  assign smp_act = init_done && smp_en;
  assign tick    = smp_act && (cnt_q == PER_LAST);
  assign dly_hit = (dly_q == DLY_LAST);

  function automatic logic [31:0] init_cmd(input logic [1:0] k);
    logic [31:0] c;
    unique case (k)
      2'd0:    c = {OP_WR, 8'h0C, 16'h0000};
      2'd1:    c = {OP_WR, 8'h10, 16'h0000};
      default: c = {OP_WR, 8'h14, 16'h0001};
    endcase
    return c;
  endfunction

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= INIT_WAIT;
      dly_q      <= '0;
      k_q        <= '0;
      frm_start  <= 1'b0;
      frm_cmd    <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      smp_valid  <= 1'b0;
      smp_data   <= '0;
      init_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      frm_start  <= start_d;
      frm_cmd    <= cmd_d;
      host_ack   <= ack_d;
      host_rdata <= rdata_d;
      smp_valid  <= valid_d;
      smp_data   <= sdata_d;
      init_done  <= init_d;
      if (state_q == INIT_WAIT) begin
        dly_q <= dly_q + 16'd1;
      end
    end
  end

  // A tick always wins over consumption so a tick on the
  // consume cycle leaves the next sample pending.
  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      smp_miss <= '0;
    end else if (!smp_act) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
      if (tick) begin
        pend_q <= 1'b1;
      end else if (consume) begin
        pend_q <= 1'b0;
      end
      if (tick && pend_q && !consume && smp_miss != 8'hFF) begin
        smp_miss <= smp_miss + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT_WAIT: begin
        if (dly_hit) state_d = INIT_ISSUE;
      end
      INIT_ISSUE: state_d = INIT_BUSY;
      INIT_BUSY: begin
        if (frm_done) begin
          state_d = (k_q == 2'd2) ? IDLE : INIT_ISSUE;
        end
      end
      IDLE: begin
        if (pend_q) begin
          state_d = SMP_BUSY;
        end else if (host_req) begin
          state_d = host_we ? HW_BUSY : HR_CMD;
        end
      end
      SMP_BUSY: begin
        if (frm_done) state_d = IDLE;
      end
      HW_BUSY: begin
        if (frm_done) state_d = IDLE;
      end
      HR_CMD: begin
        if (frm_done) state_d = HR_NOP;
      end
      HR_NOP: begin
        if (frm_done) state_d = IDLE;
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  // Start and command are registered, so frm_start rises
  // the cycle after the issuing decision.
  always_comb begin
    start_d = 1'b0;
    cmd_d   = frm_cmd;
    ack_d   = 1'b0;
    rdata_d = host_rdata;
    valid_d = 1'b0;
    sdata_d = smp_data;
    init_d  = init_done;
    k_d     = k_q;
    consume = 1'b0;
    unique case (state_q)
      INIT_WAIT: begin
        if (dly_hit) begin
          start_d = 1'b1;
          cmd_d   = init_cmd(k_q);
        end
      end
      INIT_BUSY: begin
        if (frm_done) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd2) begin
            init_d = 1'b1;
          end else begin
            start_d = 1'b1;
            cmd_d   = init_cmd(k_q + 2'd1);
          end
        end
      end
      IDLE: begin
        if (pend_q) begin
          consume = 1'b1;
          start_d = 1'b1;
          cmd_d   = CMD_NOP;
        end else if (host_req) begin
          start_d = 1'b1;
          cmd_d   = host_we ? {OP_WR, host_addr, host_wdata}
                            : {OP_RD, host_addr, 16'h0000};
        end
      end
      SMP_BUSY: begin
        if (frm_done) begin
          valid_d = 1'b1;
          sdata_d = frm_rdata[31:16];
        end
      end
      HW_BUSY: begin
        if (frm_done) ack_d = 1'b1;
      end
      HR_CMD: begin
        if (frm_done) begin
          start_d = 1'b1;
          cmd_d   = CMD_NOP;
        end
      end
      HR_NOP: begin
        if (frm_done) begin
          ack_d   = 1'b1;
          rdata_d = frm_rdata[31:16];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ads_frame_sched.sv
// tb_ads_frame_sched: directed checks of init, sampling, host access,
// miss saturation and async reset with two engine models.
module tb_ads_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   rel;

  always @(posedge clk) cyc <= cyc + 1;

  logic        smp_en_a, host_req_a, host_we_a;
  logic [7:0]  host_addr_a;
  logic [15:0] host_wdata_a, host_rdata_a, smp_data_a;
  logic        host_ack_a, frm_start_a, frm_done_a;
  logic        init_done_a, smp_valid_a;
  logic [31:0] frm_cmd_a, frm_rdata_a;
  logic [7:0]  smp_miss_a;

  logic        smp_en_b, host_req_b, host_we_b;
  logic [7:0]  host_addr_b;
  logic [15:0] host_wdata_b, host_rdata_b, smp_data_b;
  logic        host_ack_b, frm_start_b, frm_done_b;
  logic        init_done_b, smp_valid_b;
  logic [31:0] frm_cmd_b, frm_rdata_b;
  logic [7:0]  smp_miss_b;

  ads_frame_sched #(.INIT_DLY(50), .SMP_PERIOD(300)) dut_a (
    .clk_ref(clk), .sys_rstn(rstn), .smp_en(smp_en_a),
    .host_req(host_req_a), .host_we(host_we_a),
    .host_addr(host_addr_a), .host_wdata(host_wdata_a),
    .host_ack(host_ack_a), .host_rdata(host_rdata_a),
    .frm_start(frm_start_a), .frm_cmd(frm_cmd_a),
    .frm_done(frm_done_a), .frm_rdata(frm_rdata_a),
    .init_done(init_done_a), .smp_valid(smp_valid_a),
    .smp_data(smp_data_a), .smp_miss(smp_miss_a)
  );

  ads_frame_sched #(.INIT_DLY(50), .SMP_PERIOD(50)) dut_b (
    .clk_ref(clk), .sys_rstn(rstn), .smp_en(smp_en_b),
    .host_req(host_req_b), .host_we(host_we_b),
    .host_addr(host_addr_b), .host_wdata(host_wdata_b),
    .host_ack(host_ack_b), .host_rdata(host_rdata_b),
    .frm_start(frm_start_b), .frm_cmd(frm_cmd_b),
    .frm_done(frm_done_b), .frm_rdata(frm_rdata_b),
    .init_done(init_done_b), .smp_valid(smp_valid_b),
    .smp_data(smp_data_b), .smp_miss(smp_miss_b)
  );

  // engine models: done pulse lat cycles after start
  int          lat_a = 66, lat_b = 120;
  logic [31:0] nop_word_a, nop_word_b;
  int          ecnt_a, ecnt_b;
  logic        ebusy_a, ebusy_b;
  logic [31:0] ecmd_a, ecmd_b;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ebusy_a <= 0; ecnt_a <= 0; ecmd_a <= 0;
      frm_done_a <= 0; frm_rdata_a <= 0;
    end else begin
      frm_done_a <= 0;
      if (ebusy_a) begin
        if (ecnt_a == 0) begin
          frm_done_a  <= 1;
          frm_rdata_a <= (ecmd_a == 0) ? nop_word_a : 32'h5555_0000;
          ebusy_a     <= 0;
        end else ecnt_a <= ecnt_a - 1;
      end
      if (frm_start_a) begin
        ebusy_a <= 1; ecnt_a <= lat_a - 1; ecmd_a <= frm_cmd_a;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ebusy_b <= 0; ecnt_b <= 0; ecmd_b <= 0;
      frm_done_b <= 0; frm_rdata_b <= 0;
    end else begin
      frm_done_b <= 0;
      if (ebusy_b) begin
        if (ecnt_b == 0) begin
          frm_done_b  <= 1;
          frm_rdata_b <= (ecmd_b == 0) ? nop_word_b : 32'h5555_0000;
          ebusy_b     <= 0;
        end else ecnt_b <= ecnt_b - 1;
      end
      if (frm_start_b) begin
        ebusy_b <= 1; ecnt_b <= lat_b - 1; ecmd_b <= frm_cmd_b;
      end
    end
  end

  // monitors sample at the falling edge
  logic [31:0] cmd_q_a[$], cmd_q_b[$];
  int          st_q_a[$], st_q_b[$];
  int          vcnt_a = 0, acnt_a = 0, vcnt_b = 0, acnt_b = 0;
  int          last_done_a = 0, ovl_a = 0, ovl_b = 0, stepv_b = 0;
  logic [15:0] sdata_last_a = 0;
  logic        outst_a = 0, outst_b = 0;
  logic [7:0]  pmiss_b = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (frm_done_a) begin outst_a = 0; last_done_a = cyc; end
      if (frm_start_a) begin
        if (outst_a) ovl_a++;
        outst_a = 1;
        cmd_q_a.push_back(frm_cmd_a);
        st_q_a.push_back(cyc);
      end
      if (smp_valid_a) begin vcnt_a++; sdata_last_a = smp_data_a; end
      if (host_ack_a) acnt_a++;
      if (frm_done_b) outst_b = 0;
      if (frm_start_b) begin
        if (outst_b) ovl_b++;
        outst_b = 1;
        cmd_q_b.push_back(frm_cmd_b);
        st_q_b.push_back(cyc);
      end
      if (smp_valid_b) vcnt_b++;
      if (host_ack_b) acnt_b++;
      if ({1'b0, smp_miss_b} != {1'b0, pmiss_b} &&
          {1'b0, smp_miss_b} != {1'b0, pmiss_b} + 9'd1) stepv_b++;
      pmiss_b = smp_miss_b;
    end else begin
      outst_a = 0; outst_b = 0; pmiss_b = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  function automatic logic [31:0] cmda(input int i);
    if (i >= 0 && i < cmd_q_a.size()) return cmd_q_a[i];
    return 32'hDEAD_BEEF;
  endfunction
  function automatic int sta(input int i);
    if (i >= 0 && i < st_q_a.size()) return st_q_a[i];
    return -1;
  endfunction
  function automatic logic [31:0] cmdb(input int i);
    if (i >= 0 && i < cmd_q_b.size()) return cmd_q_b[i];
    return 32'hDEAD_BEEF;
  endfunction
  function automatic int stb(input int i);
    if (i >= 0 && i < st_q_b.size()) return st_q_b[i];
    return -1;
  endfunction

  task automatic seq_a();
    int c0, n, nv, na, s, n2, ta;
    for (int i = 0; i < 600 && !init_done_a; i++) wait_neg(1);
    chk("init_done", init_done_a, 1);
    chk("init_rise", cyc, last_done_a + 1);
    chk("init_nfrm", cmd_q_a.size(), 3);
    chk("init_t0", sta(0) - rel, 50);
    chk("init_k0", cmda(0), 32'hD00C_0000);
    chk("init_k1", cmda(1), 32'hD010_0000);
    chk("init_k2", cmda(2), 32'hD014_0001);

    c0 = cyc;
    smp_en_a = 1;
    for (int i = 0; i < 1000 && vcnt_a < 2; i++) wait_neg(1);
    chk("smp_cnt", vcnt_a, 2);
    chk("smp_t0", sta(3), c0 + 301);
    chk("smp_per", sta(4) - sta(3), 300);
    chk("smp_cmd", cmda(4), 32'h0);
    chk("smp_data", sdata_last_a, 16'h1234);
    chk("smp_miss", smp_miss_a, 0);

    n = cmd_q_a.size(); nv = vcnt_a; na = acnt_a;
    host_we_a = 1; host_addr_a = 8'h10; host_wdata_a = 16'hBEEF;
    host_req_a = 1;
    for (int i = 0; i < 300 && acnt_a == na; i++) wait_neg(1);
    host_req_a = 0;
    chk("hw_ack", acnt_a - na, 1);
    chk("hw_nfrm", cmd_q_a.size() - n, 1);
    chk("hw_cmd", cmda(n), 32'hD010_BEEF);
    chk("hw_nosmp", vcnt_a - nv, 0);
    chk("hw_rdata", host_rdata_a, 16'h0);
    wait_neg(1);
    chk("hw_pulse", host_ack_a, 0);

    n = cmd_q_a.size();
    for (int i = 0; i < 400 && cmd_q_a.size() == n; i++) wait_neg(1);
    s = sta(n);
    chk("hr_pre_smp", cmda(n), 32'h0);
    nop_word_a = 32'hABCD_0000;
    for (int i = 0; i < 400 && cyc < s + 260; i++) wait_neg(1);
    n2 = cmd_q_a.size(); nv = vcnt_a; na = acnt_a;
    host_we_a = 0; host_addr_a = 8'h10; host_req_a = 1;
    for (int i = 0; i < 400 && acnt_a == na; i++) wait_neg(1);
    host_req_a = 0;
    ta = cyc;
    chk("hr_ack", acnt_a - na, 1);
    chk("hr_nfrm", cmd_q_a.size() - n2, 2);
    chk("hr_cmd0", cmda(n2), 32'hC810_0000);
    chk("hr_cmd1", cmda(n2 + 1), 32'h0);
    chk("hr_rdata", host_rdata_a, 16'hABCD);
    chk("hr_nosmp", vcnt_a - nv, 0);
    chk("hr_t0", sta(n2), s + 261);
    chk("hr_tick_in", (sta(n2) < s + 299) && (sta(n2 + 1) > s + 299), 1);
    for (int i = 0; i < 50 && cmd_q_a.size() == n2 + 2; i++) wait_neg(1);
    chk("hr_smp_t", sta(n2 + 2), ta + 1);
    chk("hr_smp_cmd", cmda(n2 + 2), 32'h0);
    chk("hr_miss", smp_miss_a, 0);
    nv = vcnt_a;
    for (int i = 0; i < 200 && vcnt_a == nv; i++) wait_neg(1);
    chk("smp_abcd", sdata_last_a, 16'hABCD);
    chk("ovl_a", ovl_a, 0);
  endtask

  task automatic seq_b();
    int n;
    for (int i = 0; i < 2000 && !init_done_b; i++) wait_neg(1);
    chk("b_init", init_done_b, 1);
    chk("b_noack", acnt_b, 0);
    chk("b_nfrm", cmd_q_b.size(), 3);
    for (int i = 0; i < 300 && acnt_b == 0; i++) wait_neg(1);
    host_req_b = 0;
    chk("b_hw_ack", acnt_b, 1);
    chk("b_hw_cmd", cmdb(3), 32'hD020_1111);
    for (int i = 0; i < 40000 && smp_miss_b != 8'hFF; i++) wait_neg(1);
    chk("b_sat", smp_miss_b, 8'hFF);
    wait_neg(300);
    chk("b_sat_hold", smp_miss_b, 8'hFF);
    n = cmd_q_b.size();
    for (int i = 0; i < 400 && cmd_q_b.size() < n + 2; i++) wait_neg(1);
    chk("b_period", stb(n + 1) - stb(n), 123);
    chk("b_step", stepv_b, 0);
    chk("b_ovl", ovl_b, 0);
    chk("b_valid", vcnt_b > 100, 1);
  endtask

  initial begin
    logic found;
    rstn = 0;
    smp_en_a = 0; host_req_a = 0; host_we_a = 0;
    host_addr_a = 0; host_wdata_a = 0;
    nop_word_a = 32'h1234_0000;
    smp_en_b = 1; host_req_b = 1; host_we_b = 1;
    host_addr_b = 8'h20; host_wdata_b = 16'h1111;
    nop_word_b = 32'h5678_0000;
    wait_neg(3);
    chk("rst_start", frm_start_a, 0);
    chk("rst_cmd", frm_cmd_a, 0);
    chk("rst_init", init_done_a, 0);
    chk("rst_ack", host_ack_a, 0);
    chk("rst_miss", smp_miss_a, 0);
    @(negedge clk);
    rel = cyc;
    rstn = 1;
    fork
      seq_a();
      seq_b();
    join

    host_we_a = 1; host_addr_a = 8'h14; host_wdata_a = 16'h00AA;
    host_req_a = 1;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      wait_neg(1);
      if (frm_start_a && frm_cmd_a == 32'hD014_00AA) found = 1;
    end
    chk("ar_wr_start", found, 1);
    wait_neg(5);
    rstn = 0;
    #1;
    chk("ar_cmd", frm_cmd_a, 0);
    chk("ar_init", init_done_a, 0);
    chk("ar_sdata", smp_data_a, 0);
    chk("ar_rdata", host_rdata_a, 0);
    chk("ar_miss_b", smp_miss_b, 0);
    host_req_a = 0;
    wait_neg(3);
    rel = cyc;
    rstn = 1;
    for (int i = 0; i < 200 && !frm_start_a; i++) wait_neg(1);
    chk("ar_t0", cyc - rel, 50);
    chk("ar_k0", frm_cmd_a, 32'hD00C_0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ads_frame_sched.md
Name: ads_frame_sched

Overview:
Command scheduler in front of the ADS8686 SPI frame engine. The frame engine runs one 32-bit SPI frame per start/done handshake.
After reset this block issues the fixed ADC register-init writes. It then shares the engine between two sources: periodic sample conversions (NOP frames) and host register read/write requests.
It returns conversion results on a sample stream and register read data on the host port.

Parameters:
INIT_DLY, 50, clk_ref cycles from reset release to the first init frame start; 1..65535.
SMP_PERIOD, 2000, clk_ref cycles between sample ticks; 2..65535.

Ports:
clk_ref  in  1  system clock; all logic on its rising edge.
sys_rstn  in  1  asynchronous active-low reset.
smp_en  in  1  enables periodic sampling.
host_req  in  1  host register access request; held high until host_ack.
host_we  in  1  1=write, 0=read; stable while host_req is high.
host_addr  in  8  ADC register byte address; stable while host_req is high.
host_wdata  in  16  write data; stable while host_req is high.
host_ack  out  1  one-cycle pulse when the access completes.
host_rdata  out  16  read data; valid in the host_ack cycle.
frm_start  out  1  one-cycle pulse that starts one engine frame.
frm_cmd  out  32  frame command word; held stable from frm_start until frm_done.
frm_done  in  1  one-cycle pulse when the engine finishes the frame.
frm_rdata  in  32  word shifted in on SDO0 during the frame; valid in the frm_done cycle.
init_done  out  1  high once the init sequence has completed.
smp_valid  out  1  one-cycle pulse; a new sample is on smp_data.
smp_data  out  16  conversion result.
smp_miss  out  8  count of dropped sample ticks; saturates at 255.

Behaviour:
- Reset values: all outputs 0, frm_cmd=32'h0, state INIT_WAIT, timer 0, pending 0.
- Reset is asynchronous and may assert mid-frame. Everything returns to reset values; no handshake is completed. The engine shares sys_rstn.
- Command encodings:
  - write = {8'hD0, addr, data16}
  - read = {8'hC8, addr, 16'h0000}
  - NOP = 32'h0
- Returned data is always frm_rdata[31:16].
- State machine:
  - INIT_WAIT: count INIT_DLY cycles, then go to INIT_ISSUE.
  - INIT_ISSUE: pulse frm_start with init entry k, then go to INIT_BUSY. Init entries in order: k0 = write 0x0C←0x0000; k1 = write 0x10←0x0000; k2 = write 0x14←0x0001.
  - INIT_BUSY: on frm_done, k++. If k was 2, set init_done=1 and go to IDLE; otherwise go to INIT_ISSUE.
  - IDLE: arbitrate in priority order:
    1. sample pending: start a NOP frame, clear pending, go to SMP_BUSY.
    2. host_req with host_we=1: start a write frame, go to HW_BUSY.
    3. host_req with host_we=0: start a read frame, go to HR_CMD.
  - frm_start is asserted in the cycle after IDLE makes its decision.
  - SMP_BUSY: on frm_done, pulse smp_valid with smp_data = frm_rdata[31:16], then go to IDLE.
  - HW_BUSY: on frm_done, pulse host_ack (host_rdata unchanged), then go to IDLE.
  - HR_CMD: on frm_done, start a NOP frame next cycle and go to HR_NOP. The read response arrives in the following frame. The two frames are atomic; a pending sample waits.
  - HR_NOP: on frm_done, pulse host_ack with host_rdata = frm_rdata[31:16], then go to IDLE. No smp_valid is generated for this frame.
- Host handshake: host_req is sampled only in IDLE. If host_req is still high in the cycle after host_ack, it is a new request.
- At most one frame is outstanding at any time. frm_done outside a BUSY/CMD/NOP state is ignored.
- Sample timer:
  - Counts 0..SMP_PERIOD-1 only while init_done && smp_en; otherwise it is held at 0 and pending is cleared.
  - A tick occurs when count==SMP_PERIOD-1; count then wraps to 0.
  - Tick sets pending.
  - Tick while pending is set and not being consumed that cycle: smp_miss +1 (saturating at 255), pending stays set.
  - Tick in the same cycle pending is consumed: pending remains set, no miss.
- Before init_done, host_req is not serviced (no ack) and no sample frames are issued.

Test Plan:
1. Reset release, INIT_DLY=50, engine model with done 66 cycles after start → first frm_start 50±1 cycles after release. frm_cmd sequence D00C0000, D0100000, D0140001. init_done rises the cycle after the third frm_done.
2. smp_en=1, SMP_PERIOD=300, engine returns frm_rdata=32'h1234_0000 → NOP frames every 300 cycles, each followed by smp_valid pulse with smp_data=16'h1234. smp_miss stays 0.
3. Host write addr 0x10 data 0xBEEF → single frame with frm_cmd D010BEEF, one host_ack pulse, no smp_valid.
4. Host read addr 0x10 while a tick occurs during HR_CMD, engine second frame returns 32'hABCD_0000 → frames are C8100000 then 00000000, host_ack with host_rdata=16'hABCD. The sample NOP frame starts only after the ack.
5. SMP_PERIOD=50 with engine frame time 120 cycles → smp_miss increments once per dropped tick, saturates at 255, no more than one pending sample.
6. Assert sys_rstn low during an active frame → all outputs return to 0 immediately. After release the init sequence restarts from k0.
